// File: rtl/nco_pkg.sv
// nco_pkg: shared address map, control bit positions and widths for the NCO phase generator
package nco_pkg;
  localparam int PW_DEF = 24;
  localparam int LANES = PW_DEF / 8;
  localparam logic [3:0] A_FTW = 4'(0);
  localparam logic [3:0] A_OFF = 4'(LANES);
  localparam logic [3:0] A_STEP = 4'(2 * LANES);
  localparam logic [3:0] A_LIM = 4'(3 * LANES);
  localparam logic [3:0] A_DIV = 4'(4 * LANES);
  localparam logic [3:0] A_CTRL = 4'(4 * LANES + 1);
  localparam int C_COMMIT = 0;
  localparam int C_SWEEP = 1;
  localparam int C_CLEAR = 2;
endpackage

// File: rtl/nco_cfg_regs.sv
// nco_cfg_regs: byte-wide shadow configuration registers and commit-pending flag
module nco_cfg_regs
  import nco_pkg::*;
#(
  parameter int PW = PW_DEF,
  parameter int DIVW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cfg_wr,
  input  logic [3:0]      cfg_addr,
  input  logic [7:0]      cfg_data,
  input  logic            ack,
  output logic [PW-1:0]   ftw_sh,
  output logic [PW-1:0]   off_sh,
  output logic [PW-1:0]   step_sh,
  output logic [PW-1:0]   lim_sh,
  output logic [DIVW-1:0] div_sh,
  output logic            sweep_sh,
  output logic            clear_sh,
  output logic            pending
);
  logic commit_wr;
  assign commit_wr = cfg_wr && cfg_addr == A_CTRL && cfg_data[C_COMMIT];
  always_ff @(posedge clk) begin
    if (reset) begin
      ftw_sh <= '0;
      off_sh <= '0;
      step_sh <= '0;
      lim_sh <= '0;
      div_sh <= '0;
      sweep_sh <= 1'b0;
      clear_sh <= 1'b0;
      pending <= 1'b0;
    end else begin
      if (cfg_wr) begin
        for (int i = 0; i < PW / 8; i++) begin
          if (cfg_addr == A_FTW + 4'(i)) ftw_sh[8*i +: 8] <= cfg_data;
          if (cfg_addr == A_OFF + 4'(i)) off_sh[8*i +: 8] <= cfg_data;
          if (cfg_addr == A_STEP + 4'(i)) step_sh[8*i +: 8] <= cfg_data;
          if (cfg_addr == A_LIM + 4'(i)) lim_sh[8*i +: 8] <= cfg_data;
        end
        if (cfg_addr == A_DIV) div_sh <= DIVW'(cfg_data);
        if (cfg_addr == A_CTRL) begin
          sweep_sh <= cfg_data[C_SWEEP];
          clear_sh <= cfg_data[C_CLEAR];
        end
      end
      // a new commit request outranks the ack of the one being applied
      pending <= commit_wr | (pending & ~ack);
    end
  end
endmodule

// File: rtl/nco_phase_gen.sv
// nco_phase_gen: divided-rate phase accumulator with offset, linear FTW sweep and atomic config commit
module nco_phase_gen
  import nco_pkg::*;
#(
  parameter int PW = PW_DEF,
  parameter int DIVW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          cfg_wr,
  input  logic [3:0]    cfg_addr,
  input  logic [7:0]    cfg_data,
  output logic [PW-1:0] o_phase,
  output logic          o_valid,
  output logic          o_wrap,
  output logic          o_pending
);
  logic [PW-1:0] ftw_sh, off_sh, step_sh, lim_sh;
  logic [DIVW-1:0] div_sh;
  logic sweep_sh, clear_sh, pending;
  logic [PW-1:0] ftw_a, off_a, step_a, lim_a, acc;
  logic [DIVW-1:0] div_a, cnt;
  logic sweep_a, tick;
  logic [PW:0] acc_sum, swp_sum;
  nco_cfg_regs #(.PW(PW), .DIVW(DIVW)) u_cfg (
    .clk(clk), .reset(reset), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .ack(tick & pending), .ftw_sh(ftw_sh), .off_sh(off_sh), .step_sh(step_sh), .lim_sh(lim_sh),
    .div_sh(div_sh), .sweep_sh(sweep_sh), .clear_sh(clear_sh), .pending(pending)
  );
  assign tick = en && cnt == div_a;
  assign acc_sum = {1'b0, acc} + {1'b0, ftw_a};
  assign swp_sum = {1'b0, ftw_a} + {1'b0, step_a};
  assign o_pending = pending;
  always_ff @(posedge clk) begin
    if (reset) begin
      ftw_a <= '0;
      off_a <= '0;
      step_a <= '0;
      lim_a <= '0;
      div_a <= '0;
      sweep_a <= 1'b0;
      acc <= '0;
      cnt <= '0;
      o_phase <= '0;
      o_valid <= 1'b0;
      o_wrap <= 1'b0;
    end else begin
      o_valid <= tick;
      if (en) cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) begin
        o_phase <= acc + off_a;
        o_wrap <= acc_sum[PW];
        acc <= (pending && clear_sh) ? '0 : acc_sum[PW-1:0];
        if (pending) begin
          ftw_a <= ftw_sh;
          off_a <= off_sh;
          step_a <= step_sh;
          lim_a <= lim_sh;
          div_a <= div_sh;
          sweep_a <= sweep_sh;
        end else if (sweep_a) begin
          // overshooting the limit restarts the chirp from the shadow start value
          ftw_a <= (swp_sum > {1'b0, lim_a}) ? ftw_sh : swp_sum[PW-1:0];
        end
      end
    end
  end
endmodule
